uart_pattern_gen: RTL
=====================

// Module: uart_pattern_gen
// PURPOSE
//  Parametrised byte-pattern source feeding the UART transmitter for link bring-up and loopback tests.
//  Produces incrementing, decrementing, LFSR or fixed-value words and presents them over a start/ready handshake.
//  Bursts are either counted or endless, and completion is flagged.
//  Sits between the test-control logic (switches/registers) and the UART TX data/start inputs.
// PARAMETERS
//  DATA_W     8      width of generated word / TX data bus
//  COUNT_W    16     width of burst length and sent counter
//  LFSR_TAPS  8'hB8  Galois feedback mask (DATA_W bits); default is maximal-length for 8 bits
//  SEED       8'h01  initial word for INC/DEC/LFSR modes (DATA_W bits)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst_n       in   1        synchronous reset, active low
//  en          in   1        level: 1 = run/hold burst, 0 = return to idle
//  mode        in   2        0 INC, 1 DEC, 2 LFSR, 3 FIXED; sampled only on IDLE->RUN
//  burst_len   in   COUNT_W  words per burst, 0 = endless; sampled only on IDLE->RUN
//  fixed_val   in   DATA_W   word used in FIXED mode; sampled only on IDLE->RUN
//  tx_ready    in   1        UART TX can accept a word this cycle
//  data        out  DATA_W   word offered to TX; stable while start=1 and tx_ready=0
//  start       out  1        word valid; transfer occurs on a cycle with start & tx_ready
//  done        out  1        counted burst complete
//  sent_count  out  COUNT_W  words transferred in the current or last burst
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - state=IDLE, data=SEED, start=0, done=0, sent_count=0.
//  - Applies from any state, mid-burst included; no pending transfer survives.
//  States:
//  - IDLE: start=0, done=0. With en=1, latch mode/burst_len/fixed_val, clear sent_count,
//    and load data (SEED, fixed_val in FIXED, SEED=0 in LFSR -> 1); then go to RUN.
//  - RUN: start=1 (a registered output, so first valid appears the cycle after leaving IDLE).
//  - DONE: start=0, done=1, data and sent_count hold; en=0 -> IDLE.
//  Transfer cycle in RUN (start & tx_ready):
//  - sent_count += 1, data <= next(data) on the same edge; new word valid the next cycle.
//  - Back-to-back transfers allowed: tx_ready held high gives one word per clk.
//  - If burst_len!=0 and sent_count+1==burst_len -> DONE; start drops the next cycle.
//  - Endless burst (burst_len=0): sent_count wraps 2^COUNT_W-1 -> 0, burst continues.
//  en=0 while in RUN:
//  - A transfer in that same cycle is counted normally.
//  - Next state is IDLE, start=0; data and sent_count are held, not cleared.
//  next(data), modulo 2^DATA_W:
//  - INC: data+1 (FF->00).
//  - DEC: data-1 (00->FF).
//  - LFSR: (data>>1) ^ (data[0] ? LFSR_TAPS : 0).
//  - FIXED: data unchanged.
//  Other rules:
//  - mode, burst_len and fixed_val changes during RUN/DONE are ignored.
//  - tx_ready is ignored outside RUN.
// STRUCTURE
//  Package uart_tb_pkg:
//  - MODE_INC/MODE_DEC/MODE_LFSR/MODE_FIXED (2-bit) constants.
//  - ST_IDLE/ST_RUN/ST_DONE state encoding.
//  Sub-module galois_lfsr_step #(W,TAPS):
//  - Purely combinational next-value; reused by the UART RX checker.
//  Top: one FSM, a data register with a next-value mux, and the sent counter.
// TESTING
//  1 INC, burst_len=4, SEED=01, tx_ready=1 -> data 01,02,03,04 on 4 consecutive start cycles; done=1; sent_count=4.
//  2 INC, endless, tx_ready toggling 1/0 -> data advances only on ready cycles, holds otherwise; FF->00 wrap seen.
//  3 LFSR, SEED=01, TAPS=B8, burst 255 -> 255 distinct nonzero words, last next-value returns 01; DEC from 00 gives FF first.
//  4 FIXED, fixed_val=A5, burst 3 -> three A5 words; change fixed_val mid-burst to 3C -> still A5.
//  5 en=0 in RUN on a transfer cycle -> that word counted, start=0 next cycle, IDLE; re-enable restarts from SEED, count=0.
//  6 rst_n=0 mid-burst with start=1 -> next cycle start=0, done=0, data=SEED, sent_count=0.

Source files
------------

// File: rtl/uart_tb_pkg.sv
// Shared constants for the UART byte-pattern generator:
// word-generation modes and FSM state encoding.
package uart_tb_pkg;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_DEC   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_FIXED = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/galois_lfsr_step.sv
// One step of a right-shifting Galois LFSR.
// Purely combinational; shared with the UART RX checker.
module galois_lfsr_step #(
  parameter int unsigned      W    = 8,
  parameter logic [W-1:0]     TAPS = 8'hB8
) (
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i >> 1;
    if (cur_i[0]) begin
      nxt_o = nxt_o ^ TAPS;
    end
  end

endmodule

// File: rtl/uart_pattern_gen.sv
// Byte-pattern source for UART TX bring-up: INC/DEC/LFSR/FIXED
// words over a start/ready handshake, counted or endless bursts.
module uart_pattern_gen
  import uart_tb_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       COUNT_W   = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DATA_W-1:0] SEED      = 8'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  fixed_val,
  input  logic               tx_ready,
  output logic [DATA_W-1:0]  data,
  output logic               start,
  output logic               done,
  output logic [COUNT_W-1:0] sent_count
);

  localparam logic [DATA_W-1:0]  D_ONE = 1;
  localparam logic [COUNT_W-1:0] C_ONE = 1;

  state_e state_q, state_d;

  logic [DATA_W-1:0]  data_q, data_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [1:0]         mode_q, mode_d;

  logic [DATA_W-1:0]  lfsr_nxt;
  logic [DATA_W-1:0]  word_nxt;
  logic [DATA_W-1:0]  load_word;
  logic [COUNT_W-1:0] cnt_inc;
  logic               xfer;
  logic               last;

  galois_lfsr_step #(
    .W    (DATA_W),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .cur_i (data_q),
    .nxt_o (lfsr_nxt)
  );

  always_comb begin
    word_nxt = data_q;
    unique case (mode_q)
      MODE_INC:   word_nxt = data_q + D_ONE;
      MODE_DEC:   word_nxt = data_q - D_ONE;
      MODE_LFSR:  word_nxt = lfsr_nxt;
      MODE_FIXED: word_nxt = data_q;
      default:    word_nxt = data_q;
    endcase
  end

  // An all-zero LFSR state would lock up, so force it to 1.
  always_comb begin
    load_word = SEED;
    if (mode == MODE_FIXED) begin
      load_word = fixed_val;
    end else if (mode == MODE_LFSR && SEED == '0) begin
      load_word = D_ONE;
    end
  end

  assign cnt_inc = cnt_q + C_ONE;
  assign xfer    = (state_q == ST_RUN) && tx_ready;
  assign last    = (len_q != '0) && (cnt_inc == len_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          mode_d  = mode;
          len_d   = burst_len;
          cnt_d   = '0;
          data_d  = load_word;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          cnt_d  = cnt_inc;
          data_d = word_nxt;
        end
        if (!en) begin
          state_d = ST_IDLE;
        end else if (xfer && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_INC;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

  assign data       = data_q;
  assign start      = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign sent_count = cnt_q;

endmodule
